// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access stage: opcodes, function codes,
// error codes, FSM states and access-size encoding.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNC_JALR = 6'h09;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_store;
    size_e size;
    logic  is_signed;
  } mem_op_t;

  function automatic logic misaligned(size_e size, logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for stores,
// lane extraction with sign/zero extension for loads.
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  size_e       size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic        upper_half;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    // Big-endian lane is 3-offset, which for two bits is the inversion.
    lane       = (BIG_ENDIAN != 0) ? ~offset : offset;
    upper_half = lane[1];
    rd_byte    = rdata[{lane, 3'b000} +: 8];
    rd_half    = upper_half ? rdata[31:16] : rdata[15:0];
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{is_signed & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be        = upper_half ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{is_signed & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: write-back select for ALU/link results plus
// byte/half/word loads and stores over a req/ack port with timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [31:0]       Ins,
  input  logic [31:0]       Result,
  input  logic [31:0]       Rdata2,
  input  logic [31:0]       nextPC,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       Wdata,
  output logic [1:0]        err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state;
  logic [15:0] wait_cnt;
  size_e       size_q;
  logic        signed_q;
  logic        store_q;
  logic [1:0]  off_q;

  logic [5:0]  opcode;
  logic [5:0]  func;
  mem_op_t     dec;
  logic [31:0] nonmem_data;

  size_e       la_size;
  logic        la_signed;
  logic [1:0]  la_off;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;

  logic        unused_ins;

  assign opcode     = Ins[31:26];
  assign func       = Ins[5:0];
  assign unused_ins = ^Ins[25:6];
  assign stall      = (state != ST_IDLE);

  always_comb begin
    dec         = '0;
    nonmem_data = '0;
    case (opcode)
      OP_R_FORM: nonmem_data = (func == FUNC_JALR) ? nextPC : Result;
      OP_JAL:    nonmem_data = nextPC;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: nonmem_data = Result;
      OP_LB:  dec = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_BYTE, is_signed: 1'b1};
      OP_LBU: dec = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_BYTE, is_signed: 1'b0};
      OP_LH:  dec = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_HALF, is_signed: 1'b1};
      OP_LHU: dec = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_HALF, is_signed: 1'b0};
      OP_LW:  dec = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_WORD, is_signed: 1'b0};
      OP_SB:  dec = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_BYTE, is_signed: 1'b0};
      OP_SH:  dec = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_HALF, is_signed: 1'b0};
      OP_SW:  dec = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_WORD, is_signed: 1'b0};
      default: ;
    endcase
  end

  // One aligner serves both directions: live decode while idle (store lanes),
  // the captured access once a request is outstanding (load extraction).
  assign la_size   = (state == ST_IDLE) ? dec.size      : size_q;
  assign la_signed = (state == ST_IDLE) ? dec.is_signed : signed_q;
  assign la_off    = (state == ST_IDLE) ? Result[1:0]   : off_q;

  mau_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_align (
    .size      (la_size),
    .is_signed (la_signed),
    .offset    (la_off),
    .wdata     (Rdata2),
    .rdata     (mem_rdata),
    .be        (la_be),
    .wdata_rep (la_wdata),
    .rdata_ext (la_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      store_q   <= 1'b0;
      off_q     <= 2'b00;
      out_valid <= 1'b0;
      Wdata     <= '0;
      err       <= ERR_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          if (!dec.is_mem) begin
            out_valid <= 1'b1;
            err       <= ERR_OK;
            Wdata     <= nonmem_data;
          end else if (misaligned(dec.size, Result[1:0])) begin
            out_valid <= 1'b1;
            err       <= ERR_MISALIGN;
            Wdata     <= '0;
          end else begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            size_q    <= dec.size;
            signed_q  <= dec.is_signed;
            store_q   <= dec.is_store;
            off_q     <= Result[1:0];
            mem_req   <= 1'b1;
            mem_we    <= dec.is_store;
            mem_be    <= la_be;
            mem_addr  <= {Result[ADDR_W-1:2], 2'b00};
            mem_wdata <= la_wdata;
          end
        end
        ST_WAIT: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            err     <= ERR_OK;
            Wdata   <= store_q ? 32'h0 : la_rdata;
          end else if (wait_cnt == TO_LAST) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            err     <= ERR_TIMEOUT;
            Wdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
